bck_div_sync: RTL and testbench

//  Programmable divider for the audio bit clock, re-phased to the frame clock. Produces clk_out

---
 rtl/bck_div_sync_if.sv | 30 +++
 rtl/bck_div_sync.sv | 143 ++++++++++++++
 tb/tb_bck_div_sync.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bck_div_sync_if.sv
// Control/status bundle for bck_div_sync: the source drives enable/lrck/div_half,
// the divider returns the divided clock and lock status. frame_len exists only with BCKDIV_FRAME_MEAS_EN.
interface bck_div_sync_if #(
  parameter int DIV_W = 4
`ifdef BCKDIV_FRAME_MEAS_EN
  ,
  parameter int FRAME_W = 8
`endif
);
  logic             enable;
  logic             lrck;
  logic [DIV_W-1:0] div_half;
  logic             clk_out;
  logic             clk_rise;
  logic             locked;
  logic             slip;
`ifdef BCKDIV_FRAME_MEAS_EN
  logic [FRAME_W-1:0] frame_len;

  modport master (output enable, lrck, div_half,
                  input  clk_out, clk_rise, locked, slip, frame_len);
  modport slave  (input  enable, lrck, div_half,
                  output clk_out, clk_rise, locked, slip, frame_len);
`else
  modport master (output enable, lrck, div_half,
                  input  clk_out, clk_rise, locked, slip);
  modport slave  (input  enable, lrck, div_half,
                  output clk_out, clk_rise, locked, slip);
`endif
endinterface

// File: rtl/bck_div_sync.sv
// Bit-clock divider re-phased to lrck, with frame-alignment lock/slip tracking.
// Optional frame length measurement via `define BCKDIV_FRAME_MEAS_EN. All state moves on falling bck.
module bck_div_sync #(
  parameter int DIV_W      = 4,
`ifdef BCKDIV_FRAME_MEAS_EN
  parameter int FRAME_W    = 8,
`endif
  parameter bit BOTH_EDGES = 1'b1
) (
  input  logic          bck,
  input  logic          rst,
  bck_div_sync_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCK} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] h_act_q, h_act_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_rise_q, clk_rise_d;
  logic             locked_q, locked_d;
  logic             slip_q, slip_d;
  logic             lrck_prev_q, lrck_prev_d;

  logic [DIV_W-1:0] h_in;
  logic             lr_edge;
  logic             wrap;
  logic             aligned;

  always_comb begin
    h_in    = (bus.div_half == '0) ? DIV_W'(1) : bus.div_half;
    lr_edge = BOTH_EDGES ? (bus.lrck ^ lrck_prev_q) : (bus.lrck & ~lrck_prev_q);
    wrap    = (cnt_q == h_act_q - DIV_W'(1));
    // a frame edge is aligned only when it closes a complete high-low output period
    aligned = lr_edge & wrap & clk_out_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    h_act_d     = h_act_q;
    clk_out_d   = clk_out_q;
    locked_d    = locked_q;
    slip_d      = 1'b0;
    lrck_prev_d = bus.lrck;

    if (!bus.enable || state_q == IDLE) begin
      state_d   = bus.enable ? ACQ : IDLE;
      cnt_d     = '0;
      clk_out_d = 1'b0;
      locked_d  = 1'b0;
      h_act_d   = h_in;
    end else if (lr_edge) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      h_act_d   = h_in;
      unique case (state_q)
        ACQ:   state_d = TRACK;
        TRACK: if (aligned) begin
                 state_d  = LOCK;
                 locked_d = 1'b1;
               end
        LOCK:  if (!aligned) begin
                 state_d  = TRACK;
                 locked_d = 1'b0;
                 slip_d   = 1'b1;
               end
        default: state_d = IDLE;
      endcase
    end else if (wrap) begin
      // div_half changes take effect only at half-period boundaries
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      h_act_d   = h_in;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    clk_rise_d = clk_out_d & ~clk_out_q;
  end

  always_ff @(negedge bck) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      h_act_q     <= DIV_W'(1);
      clk_out_q   <= 1'b0;
      clk_rise_q  <= 1'b0;
      locked_q    <= 1'b0;
      slip_q      <= 1'b0;
      lrck_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      h_act_q     <= h_act_d;
      clk_out_q   <= clk_out_d;
      clk_rise_q  <= clk_rise_d;
      locked_q    <= locked_d;
      slip_q      <= slip_d;
      lrck_prev_q <= lrck_prev_d;
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.clk_rise = clk_rise_q;
  assign bus.locked   = locked_q;
  assign bus.slip     = slip_q;

`ifdef BCKDIV_FRAME_MEAS_EN
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic [FRAME_W-1:0] frame_len_q, frame_len_d;
  logic [FRAME_W-1:0] fcnt_inc;

  always_comb begin
    fcnt_inc    = (fcnt_q == '1) ? fcnt_q : fcnt_q + FRAME_W'(1);
    fcnt_d      = fcnt_q;
    frame_len_d = frame_len_q;
    if (!bus.enable || state_q == IDLE) begin
      fcnt_d = '0;
    end else if (lr_edge) begin
      // the edge cycle itself closes the frame, hence the +1
      frame_len_d = fcnt_inc;
      fcnt_d      = '0;
    end else begin
      fcnt_d = fcnt_inc;
    end
  end

  always_ff @(negedge bck) begin
    if (rst) begin
      fcnt_q      <= '0;
      frame_len_q <= '0;
    end else begin
      fcnt_q      <= fcnt_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign bus.frame_len = frame_len_q;
`endif

endmodule

// File: tb/tb_bck_div_sync.sv
// Randomized + directed bench for bck_div_sync against a cycle-level behavioural model.
// Frame-length checks (FRAME_W=8 and a saturating FRAME_W=4 instance) only with BCKDIV_FRAME_MEAS_EN.
module tb_bck_div_sync;
  localparam int DIV_W      = 4;
  localparam bit BOTH_EDGES = 1'b1;

  logic bck = 1'b0;
  logic rst;
  logic lr;
  int   n_chk = 0;
  int   n_err = 0;
  int   slip_seen = 0;

  always #5 bck = ~bck;

`ifdef BCKDIV_FRAME_MEAS_EN
  bck_div_sync_if #(.DIV_W(DIV_W), .FRAME_W(8)) bus ();
  bck_div_sync_if #(.DIV_W(DIV_W), .FRAME_W(4)) bus4 ();

  bck_div_sync #(.DIV_W(DIV_W), .FRAME_W(8), .BOTH_EDGES(BOTH_EDGES)) dut (
    .bck(bck), .rst(rst), .bus(bus.slave));
  bck_div_sync #(.DIV_W(DIV_W), .FRAME_W(4), .BOTH_EDGES(BOTH_EDGES)) dut4 (
    .bck(bck), .rst(rst), .bus(bus4.slave));

  assign bus4.enable   = bus.enable;
  assign bus4.lrck     = bus.lrck;
  assign bus4.div_half = bus.div_half;
`else
  bck_div_sync_if #(.DIV_W(DIV_W)) bus ();

  bck_div_sync #(.DIV_W(DIV_W), .BOTH_EDGES(BOTH_EDGES)) dut (
    .bck(bck), .rst(rst), .bus(bus.slave));
`endif

  // reference model: output level and position inside the current half-period,
  // plus "seen first edge" / "locked" flags; frame count kept unbounded
  bit m_active, m_seen, m_lock, m_level, m_rise, m_slip, m_prev;
  int m_pos, m_h, m_fc, m_fl8, m_fl4;

  task automatic model(input bit r, input bit e, input bit l, input int dh);
    int hn;
    bit ev, al;
    hn = (dh == 0) ? 1 : dh;
    if (r) begin
      m_active = 0; m_seen = 0; m_lock = 0; m_level = 0; m_rise = 0; m_slip = 0;
      m_prev = 0; m_pos = 0; m_h = 1; m_fc = 0; m_fl8 = 0; m_fl4 = 0;
      return;
    end
    ev = BOTH_EDGES ? (l != m_prev) : (l && !m_prev);
    m_prev = l;
    m_rise = 0;
    m_slip = 0;
    if (!e || !m_active) begin
      m_active = e; m_seen = 0; m_lock = 0; m_level = 0; m_pos = 0; m_h = hn; m_fc = 0;
    end else if (ev) begin
      al = (m_pos == m_h - 1) && m_level;
      if (m_seen) begin
        m_slip = m_lock && !al;
        m_lock = al;
      end
      m_seen = 1; m_level = 0; m_pos = 0; m_h = hn;
      m_fl8 = (m_fc + 1 > 255) ? 255 : m_fc + 1;
      m_fl4 = (m_fc + 1 > 15) ? 15 : m_fc + 1;
      m_fc = 0;
    end else begin
      m_fc++;
      if (m_pos == m_h - 1) begin
        m_pos = 0; m_level = !m_level; m_rise = m_level; m_h = hn;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic l, input int dh);
    rst          = r;
    bus.enable   = e;
    bus.lrck     = l;
    bus.div_half = dh[DIV_W-1:0];
    model(r, e, l, dh);
    @(negedge bck);
    #1;
    if (bus.slip === 1'b1) slip_seen++;
    chk("clk_out",  {31'd0, bus.clk_out},  {31'd0, m_level});
    chk("clk_rise", {31'd0, bus.clk_rise}, {31'd0, m_rise});
    chk("locked",   {31'd0, bus.locked},   {31'd0, m_lock});
    chk("slip",     {31'd0, bus.slip},     {31'd0, m_slip});
`ifdef BCKDIV_FRAME_MEAS_EN
    chk("frame_len8", {24'd0, bus.frame_len},  m_fl8);
    chk("frame_len4", {28'd0, bus4.frame_len}, m_fl4);
`endif
  endtask

  task automatic halves(input int dh, input int half, input int n);
    for (int i = 0; i < n; i++) begin
      lr = ~lr;
      for (int j = 0; j < half; j++) cyc(1'b0, 1'b1, lr, dh);
    end
  endtask

  task automatic idle(input int n, input int dh);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, lr, dh);
  endtask

  initial begin
    int half, dh;
    lr = 1'b0;

    // reset with lrck toggling and enable high
    for (int i = 0; i < 3; i++) begin
      lr = ~lr;
      cyc(1'b1, 1'b1, lr, 1);
    end
    idle(2, 1);

    // h=1, 32-cycle half frames
    halves(1, 32, 5);
    chk("h1_locked", {31'd0, bus.locked}, 32'd1);

    // h=4, re-acquire from idle
    idle(2, 4);
    halves(4, 32, 5);
    chk("h4_locked", {31'd0, bus.locked}, 32'd1);

    // locked at h=1, one half stretched to 33 cycles
    idle(2, 1);
    halves(1, 32, 4);
    slip_seen = 0;
    halves(1, 33, 1);
    halves(1, 32, 1);
    chk("stretch_slip_cnt", slip_seen, 32'd1);
    halves(1, 32, 1);
    chk("relock", {31'd0, bus.locked}, 32'd1);

    // div_half 2 -> 4 partway through a half-period
    halves(2, 32, 3);
    lr = ~lr;
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, lr, 2);
    for (int j = 3; j < 32; j++) cyc(1'b0, 1'b1, lr, 4);
    halves(4, 32, 2);

    // max half-period and div_half=0
    idle(2, 15);
    halves(15, 30, 4);
    chk("h15_locked", {31'd0, bus.locked}, 32'd1);
    halves(0, 32, 4);
    chk("h0_locked", {31'd0, bus.locked}, 32'd1);

    // random segments
    for (int s = 0; s < 80; s++) begin
      dh = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) half = 2 * ((dh == 0) ? 1 : dh) * $urandom_range(1, 3);
      else half = $urandom_range(1, 40);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3), dh);
      if ($urandom_range(0, 29) == 0) begin
        cyc(1'b1, 1'b1, lr, dh);
        cyc(1'b1, 1'b1, lr, dh);
      end
      lr = ~lr;
      for (int j = 0; j < half; j++) begin
        if (j == half / 2 && $urandom_range(0, 3) == 0) dh = $urandom_range(0, 15);
        cyc(1'b0, 1'b1, lr, dh);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
